// File: rtl/bellek_hakemi.sv
// rtl/bellek_hakemi.sv - two-requester (fetch / BIB) memory bus arbiter with stall timeout
module bellek_hakemi #(
  parameter int unsigned ZAMAN_ASIMI = 1024
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        ps_sec_i,
  input  logic [31:0] ps_adr_i,
  output logic [31:0] ps_veri_o,
  output logic        ps_durdur_o,
  input  logic        bib_sec_i,
  input  logic [31:0] bib_adr_i,
  input  logic [31:0] bib_veri_i,
  input  logic [3:0]  bib_veri_maske_i,
  output logic [31:0] bib_veri_o,
  output logic        bib_durdur_o,
  output logic        bellek_sec_o,
  output logic [31:0] bellek_adr_o,
  output logic [31:0] bellek_veri_o,
  output logic [3:0]  bellek_veri_maske_o,
  input  logic [31:0] bellek_veri_i,
  input  logic        bellek_durdur_i,
  output logic        hata_o
);

  typedef enum logic [1:0] {
    BOSTA     = 2'd0,
    PS_AKTIF  = 2'd1,
    BIB_AKTIF = 2'd2
  } durum_t;

  localparam logic        HIZMET_PS  = 1'b0;
  localparam logic        HIZMET_BIB = 1'b1;
  localparam logic [15:0] SAYAC_SON  = 16'(ZAMAN_ASIMI - 1);

  durum_t      durum_q, durum_d;
  logic        son_hizmet_q, son_hizmet_d;
  logic [15:0] sayac_q, sayac_d;
  logic [31:0] adr_q, adr_d;
  logic [31:0] veri_q, veri_d;
  logic [3:0]  maske_q, maske_d;

  logic aktif;
  logic zaman_asimi;
  logic bitis;
  logic ps_bitis;
  logic bib_bitis;
  logic ps_aday;
  logic bib_aday;
  logic kazanan_ps;
  logic kazanan_bib;

  // Transaction end detection and arbitration; the finishing requester is masked out
  always_comb begin
    aktif       = (durum_q != BOSTA);
    zaman_asimi = aktif && !rst_i && bellek_durdur_i && (sayac_q == SAYAC_SON);
    bitis       = aktif && !rst_i && (!bellek_durdur_i || zaman_asimi);
    ps_bitis    = bitis && (durum_q == PS_AKTIF);
    bib_bitis   = bitis && (durum_q == BIB_AKTIF);
    ps_aday     = ps_sec_i && !ps_bitis;
    bib_aday    = bib_sec_i && !bib_bitis;
    kazanan_bib = bib_aday && (!ps_aday || (son_hizmet_q == HIZMET_PS));
    kazanan_ps  = ps_aday && !kazanan_bib;
  end

  // Next-state, fairness record, timeout counter and operand capture
  always_comb begin
    durum_d      = durum_q;
    son_hizmet_d = son_hizmet_q;
    sayac_d      = sayac_q;
    adr_d        = adr_q;
    veri_d       = veri_q;
    maske_d      = maske_q;
    if ((durum_q == BOSTA) || bitis) begin
      sayac_d = 16'd0;
      if (bitis) begin
        son_hizmet_d = (durum_q == BIB_AKTIF) ? HIZMET_BIB : HIZMET_PS;
      end
      if (kazanan_bib) begin
        durum_d = BIB_AKTIF;
        adr_d   = bib_adr_i;
        veri_d  = bib_veri_i;
        maske_d = bib_veri_maske_i;
      end else if (kazanan_ps) begin
        durum_d = PS_AKTIF;
        adr_d   = ps_adr_i;
        veri_d  = 32'd0;
        maske_d = 4'd0;
      end else begin
        durum_d = BOSTA;
      end
    end else if (bellek_durdur_i) begin
      sayac_d = sayac_q + 16'd1;
    end
  end

  // State register with synchronous reset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      durum_q      <= BOSTA;
      son_hizmet_q <= HIZMET_PS;
      sayac_q      <= 16'd0;
      adr_q        <= 32'd0;
      veri_q       <= 32'd0;
      maske_q      <= 4'd0;
    end else begin
      durum_q      <= durum_d;
      son_hizmet_q <= son_hizmet_d;
      sayac_q      <= sayac_d;
      adr_q        <= adr_d;
      veri_q       <= veri_d;
      maske_q      <= maske_d;
    end
  end

  // Requester-side outputs; aborted or abandoned transactions return zero data
  always_comb begin
    ps_durdur_o         = ps_sec_i && !ps_bitis;
    bib_durdur_o        = bib_sec_i && !bib_bitis;
    ps_veri_o           = (ps_bitis && ps_sec_i && !zaman_asimi) ? bellek_veri_i : 32'd0;
    bib_veri_o          = (bib_bitis && bib_sec_i && !zaman_asimi) ? bellek_veri_i : 32'd0;
    bellek_sec_o        = aktif;
    bellek_adr_o        = adr_q;
    bellek_veri_o       = veri_q;
    bellek_veri_maske_o = maske_q;
    hata_o              = zaman_asimi;
  end

endmodule

// File: tb/tb_bellek_hakemi.sv
// tb/tb_bellek_hakemi.sv - scoreboard bench for bellek_hakemi
module tb_bellek_hakemi;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        ps_sec_i;
  logic [31:0] ps_adr_i;
  logic [31:0] ps_veri_o;
  logic        ps_durdur_o;
  logic        bib_sec_i;
  logic [31:0] bib_adr_i;
  logic [31:0] bib_veri_i;
  logic [3:0]  bib_veri_maske_i;
  logic [31:0] bib_veri_o;
  logic        bib_durdur_o;
  logic        bellek_sec_o;
  logic [31:0] bellek_adr_o;
  logic [31:0] bellek_veri_o;
  logic [3:0]  bellek_veri_maske_o;
  logic [31:0] bellek_veri_i;
  logic        bellek_durdur_i;
  logic        hata_o;

  typedef struct {
    logic        is_bib;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [3:0]  maske;
    logic [31:0] rdata;
  } beklenen_t;

  beklenen_t sb[$];
  beklenen_t mon_e;
  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  bellek_hakemi #(.ZAMAN_ASIMI(8)) dut (
    .clk_i               (clk),
    .rst_i               (rst_i),
    .ps_sec_i            (ps_sec_i),
    .ps_adr_i            (ps_adr_i),
    .ps_veri_o           (ps_veri_o),
    .ps_durdur_o         (ps_durdur_o),
    .bib_sec_i           (bib_sec_i),
    .bib_adr_i           (bib_adr_i),
    .bib_veri_i          (bib_veri_i),
    .bib_veri_maske_i    (bib_veri_maske_i),
    .bib_veri_o          (bib_veri_o),
    .bib_durdur_o        (bib_durdur_o),
    .bellek_sec_o        (bellek_sec_o),
    .bellek_adr_o        (bellek_adr_o),
    .bellek_veri_o       (bellek_veri_o),
    .bellek_veri_maske_o (bellek_veri_maske_o),
    .bellek_veri_i       (bellek_veri_i),
    .bellek_durdur_i     (bellek_durdur_i),
    .hata_o              (hata_o)
  );

  function automatic logic [31:0] bus_veri(input logic [31:0] adr);
    return (adr == 32'h4000_0010) ? 32'hDEAD_BEEF : (adr ^ 32'h5A5A_A5A5);
  endfunction

  assign bellek_veri_i = bus_veri(bellek_adr_o);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic push(input logic is_bib, input logic [31:0] adr, input logic [31:0] wdata,
                      input logic [3:0] maske);
    beklenen_t e;
    e.is_bib = is_bib;
    e.adr    = adr;
    e.wdata  = wdata;
    e.maske  = maske;
    e.rdata  = bus_veri(adr);
    sb.push_back(e);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // Completion monitor: every downstream completion must match the next scoreboard entry
  always @(negedge clk) begin
    if (!rst_i && bellek_sec_o && !bellek_durdur_i) begin
      tests++;
      assert (sb.size() != 0) else begin
        fails++;
        $error("FAIL sb_underflow: observed completion at adr %h expected none", bellek_adr_o);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("mon_adr", bellek_adr_o, mon_e.adr);
        chk("mon_wdata", bellek_veri_o, mon_e.wdata);
        chk("mon_mask", {28'd0, bellek_veri_maske_o}, {28'd0, mon_e.maske});
        chk1("mon_hata", hata_o, 1'b0);
        if (mon_e.is_bib) begin
          chk1("mon_bib_durdur", bib_durdur_o, 1'b0);
          chk("mon_bib_veri", bib_veri_o, mon_e.rdata);
          chk("mon_ps_veri", ps_veri_o, 32'd0);
        end else begin
          chk1("mon_ps_durdur", ps_durdur_o, 1'b0);
          chk("mon_ps_veri", ps_veri_o, mon_e.rdata);
          chk("mon_bib_veri", bib_veri_o, 32'd0);
        end
      end
    end
  end

  initial begin
    rst_i = 1'b1;
    ps_sec_i = 1'b1;
    ps_adr_i = 32'd0;
    bib_sec_i = 1'b0;
    bib_adr_i = 32'd0;
    bib_veri_i = 32'd0;
    bib_veri_maske_i = 4'd0;
    bellek_durdur_i = 1'b0;

    // reset state
    smp();
    chk1("rst_ps_durdur", ps_durdur_o, 1'b1);
    chk1("rst_bib_durdur", bib_durdur_o, 1'b0);
    chk1("rst_sec", bellek_sec_o, 1'b0);
    chk("rst_adr", bellek_adr_o, 32'd0);
    chk("rst_veri", bellek_veri_o, 32'd0);
    chk("rst_mask", {28'd0, bellek_veri_maske_o}, 32'd0);
    chk1("rst_hata", hata_o, 1'b0);
    chk("rst_ps_veri", ps_veri_o, 32'd0);
    cyc();
    rst_i = 1'b0;
    ps_sec_i = 1'b0;

    // single read
    cyc();
    bib_sec_i = 1'b1;
    bib_adr_i = 32'h4000_0010;
    push(1'b1, 32'h4000_0010, 32'd0, 4'd0);
    smp();
    chk1("rd_c0_sec", bellek_sec_o, 1'b0);
    chk1("rd_c0_durdur", bib_durdur_o, 1'b1);
    cyc();
    smp();
    chk1("rd_c1_sec", bellek_sec_o, 1'b1);
    chk1("rd_c1_durdur", bib_durdur_o, 1'b0);
    chk("rd_c1_veri", bib_veri_o, 32'hDEAD_BEEF);
    cyc();
    bib_sec_i = 1'b0;
    smp();
    chk1("rd_c2_sec", bellek_sec_o, 1'b0);

    // contention fairness from reset
    cyc();
    rst_i = 1'b1;
    cyc();
    rst_i = 1'b0;
    ps_sec_i = 1'b1;
    ps_adr_i = 32'h0000_1000;
    bib_sec_i = 1'b1;
    bib_adr_i = 32'h2000_0000;
    bib_veri_i = 32'hAAAA_0001;
    bib_veri_maske_i = 4'hF;
    push(1'b1, 32'h2000_0000, 32'hAAAA_0001, 4'hF);
    push(1'b0, 32'h0000_1000, 32'd0, 4'd0);
    push(1'b1, 32'h2000_0004, 32'hBBBB_0002, 4'hC);
    push(1'b0, 32'h0000_1004, 32'd0, 4'd0);
    smp();
    chk1("ct_c0_sec", bellek_sec_o, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      if (k == 2) begin
        bib_adr_i = 32'h2000_0004;
        bib_veri_i = 32'hBBBB_0002;
        bib_veri_maske_i = 4'hC;
      end
      if (k == 3) ps_adr_i = 32'h0000_1004;
      if (k == 4) bib_sec_i = 1'b0;
      smp();
      chk1($sformatf("ct_c%0d_sec", k), bellek_sec_o, 1'b1);
      chk1($sformatf("ct_c%0d_bib_durdur", k), bib_durdur_o, k == 2);
      chk1($sformatf("ct_c%0d_ps_durdur", k), ps_durdur_o, (k == 1) || (k == 3));
    end
    cyc();
    ps_sec_i = 1'b0;
    smp();
    chk1("ct_end_sec", bellek_sec_o, 1'b0);

    // write with 5 stall cycles
    cyc();
    bib_sec_i = 1'b1;
    bib_adr_i = 32'h3000_0020;
    bib_veri_i = 32'h1234_5678;
    bib_veri_maske_i = 4'b0011;
    bellek_durdur_i = 1'b1;
    push(1'b1, 32'h3000_0020, 32'h1234_5678, 4'b0011);
    smp();
    chk1("wr_c0_sec", bellek_sec_o, 1'b0);
    for (int k = 1; k <= 6; k++) begin
      cyc();
      if (k == 6) bellek_durdur_i = 1'b0;
      smp();
      chk1($sformatf("wr_c%0d_sec", k), bellek_sec_o, 1'b1);
      chk($sformatf("wr_c%0d_adr", k), bellek_adr_o, 32'h3000_0020);
      chk($sformatf("wr_c%0d_veri", k), bellek_veri_o, 32'h1234_5678);
      chk($sformatf("wr_c%0d_mask", k), {28'd0, bellek_veri_maske_o}, 32'h3);
      chk1($sformatf("wr_c%0d_durdur", k), bib_durdur_o, k < 6);
    end
    cyc();
    bib_sec_i = 1'b0;
    smp();
    chk1("wr_end_sec", bellek_sec_o, 1'b0);

    // reset during the 3rd stalled cycle of a BIB write
    cyc();
    bib_sec_i = 1'b1;
    bib_adr_i = 32'h3000_0040;
    bib_veri_i = 32'hCAFE_0000;
    bib_veri_maske_i = 4'hF;
    bellek_durdur_i = 1'b1;
    cyc();
    smp();
    chk1("rm_c1_sec", bellek_sec_o, 1'b1);
    cyc();
    cyc();
    rst_i = 1'b1;
    smp();
    chk1("rm_c3_durdur", bib_durdur_o, 1'b1);
    chk("rm_c3_veri", bib_veri_o, 32'd0);
    chk1("rm_c3_hata", hata_o, 1'b0);
    cyc();
    rst_i = 1'b0;
    bellek_durdur_i = 1'b0;
    bib_adr_i = 32'h3000_0080;
    bib_veri_i = 32'h0BAD_F00D;
    ps_sec_i = 1'b1;
    ps_adr_i = 32'h0000_2000;
    push(1'b1, 32'h3000_0080, 32'h0BAD_F00D, 4'hF);
    push(1'b0, 32'h0000_2000, 32'd0, 4'd0);
    smp();
    chk1("rm_c4_sec", bellek_sec_o, 1'b0);
    chk("rm_c4_adr", bellek_adr_o, 32'd0);
    chk("rm_c4_veri", bellek_veri_o, 32'd0);
    chk("rm_c4_mask", {28'd0, bellek_veri_maske_o}, 32'd0);
    chk1("rm_c4_bib_durdur", bib_durdur_o, 1'b1);
    chk1("rm_c4_ps_durdur", ps_durdur_o, 1'b1);
    cyc();
    smp();
    chk1("rm_c5_sec", bellek_sec_o, 1'b1);
    chk1("rm_c5_bib_durdur", bib_durdur_o, 1'b0);
    chk1("rm_c5_ps_durdur", ps_durdur_o, 1'b1);
    cyc();
    bib_sec_i = 1'b0;
    smp();
    chk1("rm_c6_sec", bellek_sec_o, 1'b1);
    chk1("rm_c6_ps_durdur", ps_durdur_o, 1'b0);
    cyc();
    ps_sec_i = 1'b0;
    smp();
    chk1("rm_c7_sec", bellek_sec_o, 1'b0);

    // timeout abort on a fetch
    cyc();
    ps_sec_i = 1'b1;
    ps_adr_i = 32'h0000_3000;
    bellek_durdur_i = 1'b1;
    smp();
    chk1("to_c0_sec", bellek_sec_o, 1'b0);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      smp();
      chk1($sformatf("to_c%0d_sec", k), bellek_sec_o, 1'b1);
      chk1($sformatf("to_c%0d_hata", k), hata_o, k == 8);
      chk1($sformatf("to_c%0d_durdur", k), ps_durdur_o, k != 8);
      chk($sformatf("to_c%0d_veri", k), ps_veri_o, 32'd0);
    end
    cyc();
    ps_sec_i = 1'b0;
    bellek_durdur_i = 1'b0;
    smp();
    chk1("to_end_sec", bellek_sec_o, 1'b0);
    chk1("to_end_hata", hata_o, 1'b0);

    chk("sb_leftover", 32'(sb.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
